// File: rtl/fir_sample_ctrl.sv
// fir_sample_ctrl: sample-rate controller that feeds the adaptive FIR, supervises completion and buffers one result
module fir_sample_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_x,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_err,
    input  logic [15:0]      mu,
    output logic [15:0]      fir_x,
    output logic [15:0]      fir_a,
    output logic [15:0]      fir_wadj,
    output logic             fir_go,
    input  logic             fir_done,
    input  logic [15:0]      fir_sample,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sample,
    output logic             timeout_err,
    input  logic             clr_err,
    output logic [CNT_W-1:0] sample_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, MULT, GO, WAIT} state_t;
    state_t state_q, state_d;
    logic signed [15:0] x_q, x_d, a_q, a_d, err_q, err_d, mu_q, mu_d;
    logic [15:0] fx_q, fx_d, fa_q, fa_d, wadj_q, wadj_d, osmp_q, osmp_d, wadj_sat;
    logic ov_q, ov_d, terr_q, terr_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic signed [31:0] p;
    logic signed [16:0] q;
    assign p        = 32'(mu_q) * 32'(err_q);
    assign q        = 17'(p >>> 15);
    assign wadj_sat = (q[16] == q[15]) ? q[15:0] : (q[16] ? 16'h8000 : 16'h7fff);
    assign in_ready    = (state_q == IDLE) && !ov_q;
    assign fir_go      = state_q == GO;
    assign fir_x       = fx_q;
    assign fir_a       = fa_q;
    assign fir_wadj    = wadj_q;
    assign out_valid   = ov_q;
    assign out_sample  = osmp_q;
    assign timeout_err = terr_q;
    assign sample_cnt  = cnt_q;
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        a_d     = a_q;
        err_d   = err_q;
        mu_d    = mu_q;
        fx_d    = fx_q;
        fa_d    = fa_q;
        wadj_d  = wadj_q;
        osmp_d  = osmp_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q && !out_ready;
        terr_d  = terr_q && !clr_err;
        case (state_q)
            IDLE: if (in_valid && in_ready) begin
                x_d     = in_x;
                a_d     = in_a;
                err_d   = in_err;
                mu_d    = mu;
                state_d = MULT;
            end
            MULT: begin
                fx_d    = x_q;
                fa_d    = a_q;
                wadj_d  = wadj_sat;
                state_d = GO;
            end
            GO: begin
                tmr_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (fir_done) begin
                osmp_d  = fir_sample;
                ov_d    = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = IDLE;
            end else if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
                terr_d  = 1'b1;
                state_d = IDLE;
            end else begin
                tmr_d   = tmr_q + TW'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            a_q     <= '0;
            err_q   <= '0;
            mu_q    <= '0;
            fx_q    <= '0;
            fa_q    <= '0;
            wadj_q  <= '0;
            osmp_q  <= '0;
            tmr_q   <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            a_q     <= a_d;
            err_q   <= err_d;
            mu_q    <= mu_d;
            fx_q    <= fx_d;
            fa_q    <= fa_d;
            wadj_q  <= wadj_d;
            osmp_q  <= osmp_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            terr_q  <= terr_d;
        end
    end
endmodule

// File: tb/tb_fir_sample_ctrl.sv
// tb_fir_sample_ctrl: directed checks of handshake, saturation, backpressure, timeout, reset and counter wrap
module tb_fir_sample_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, fir_done = 1'b0, out_ready = 1'b0, clr_err = 1'b0;
    logic [15:0] in_x = '0, in_a = '0, in_err = '0, mu = '0, fir_sample = '0;
    logic        in_ready, fir_go, out_valid, timeout_err;
    logic [15:0] fir_x, fir_a, fir_wadj, out_sample;
    logic [3:0]  sample_cnt;
    int passed = 0;
    int total  = 0;
    fir_sample_ctrl #(.TIMEOUT_CYC(255), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_a(in_a), .in_err(in_err), .mu(mu),
        .fir_x(fir_x), .fir_a(fir_a), .fir_wadj(fir_wadj), .fir_go(fir_go),
        .fir_done(fir_done), .fir_sample(fir_sample),
        .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
        .timeout_err(timeout_err), .clr_err(clr_err), .sample_cnt(sample_cnt)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    // Presents a sample set and returns just after the accepting edge.
    task automatic send(input logic [15:0] x, a, e, m);
        int n = 0;
        in_valid = 1'b1; in_x = x; in_a = a; in_err = e; mu = m;
        while (!in_ready && n < 100) begin step(); n++; end
        chk("send_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask
    // Full transaction: go latency check, FIR answers 4 cycles after go, result drained.
    task automatic txn(input logic [15:0] x, a, e, m, smp, output logic [15:0] wadj);
        send(x, a, e, m);
        step();
        chk("go_latency", fir_go, 1);
        wadj = fir_wadj;
        repeat (3) step();
        fir_done = 1'b1; fir_sample = smp;
        step();
        fir_done = 1'b0;
        chk("txn_out", out_sample, smp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask
    initial begin
        logic [15:0] w, held;
        int gocnt, bad, rdy;
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_go", fir_go, 0);
        chk("rst_wadj", fir_wadj, 0);
        chk("rst_out_sample", out_sample, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_cnt", sample_cnt, 0);
        rst = 1'b0;
        // basic flow
        send(16'h0100, 16'h0200, 16'h2000, 16'h4000);
        chk("mult_in_ready", in_ready, 0);
        chk("mult_go", fir_go, 0);
        step();
        chk("basic_go", fir_go, 1);
        chk("basic_wadj", fir_wadj, 16'h1000);
        chk("basic_x", fir_x, 16'h0100);
        chk("basic_a", fir_a, 16'h0200);
        gocnt = 0; bad = 0;
        for (int i = 0; i < 133; i++) begin
            step();
            gocnt += int'(fir_go);
            if (fir_x !== 16'h0100 || fir_a !== 16'h0200 || fir_wadj !== 16'h1000 || in_ready !== 1'b0) bad++;
        end
        chk("basic_go_once", gocnt, 0);
        chk("basic_hold", bad, 0);
        chk("basic_pre_done", out_valid, 0);
        fir_done = 1'b1; fir_sample = 16'h1234;
        step();
        fir_done = 1'b0;
        chk("basic_ov", out_valid, 1);
        chk("basic_sample", out_sample, 16'h1234);
        chk("basic_cnt", sample_cnt, 1);
        chk("basic_busy", in_ready, 0);
        // backpressure with a pending input
        in_valid = 1'b1; in_x = 16'h0300; in_a = 16'h0400; in_err = 16'h4000; mu = 16'h4000;
        rdy = 0; bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            rdy += int'(in_ready);
            if (out_sample !== 16'h1234 || out_valid !== 1'b1) bad++;
        end
        chk("bp_ready", rdy, 0);
        chk("bp_stable", bad, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_drop", out_valid, 0);
        chk("bp_ready_back", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_accept", in_ready, 0);
        step();
        chk("bp_go", fir_go, 1);
        chk("bp_wadj", fir_wadj, 16'h2000);
        chk("bp_x", fir_x, 16'h0300);
        repeat (3) step();
        fir_done = 1'b1; fir_sample = 16'hBEEF;
        step();
        fir_done = 1'b0;
        chk("bp_sample", out_sample, 16'hBEEF);
        chk("bp_cnt", sample_cnt, 2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_drain", out_valid, 0);
        // saturation
        txn(16'h0001, 16'h0002, 16'h8000, 16'h8000, 16'h1111, w);
        chk("sat_pos", w, 16'h7FFF);
        txn(16'h0003, 16'h0004, 16'h8000, 16'h7FFF, 16'h2222, w);
        chk("sat_neg", w, 16'h8001);
        txn(16'h0005, 16'h0006, 16'h4000, 16'hC000, 16'h3333, w);
        chk("mul_neg", w, 16'hE000);
        chk("sat_cnt", sample_cnt, 5);
        // timeout
        send(16'h0007, 16'h0008, 16'h0100, 16'h0100);
        step();
        chk("to_go", fir_go, 1);
        repeat (255) step();
        chk("to_not_yet", timeout_err, 0);
        chk("to_busy", in_ready, 0);
        step();
        chk("to_flag", timeout_err, 1);
        chk("to_no_out", out_valid, 0);
        chk("to_ready", in_ready, 1);
        fir_done = 1'b1; fir_sample = 16'h4444;
        step();
        fir_done = 1'b0;
        chk("late_done_ov", out_valid, 0);
        chk("late_done_cnt", sample_cnt, 5);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_err", timeout_err, 0);
        send(16'h0009, 16'h000A, 16'h0100, 16'h0100);
        step();
        repeat (255) step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("set_wins", timeout_err, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_again", timeout_err, 0);
        // reset mid-WAIT
        send(16'h000B, 16'h000C, 16'h0100, 16'h0100);
        step();
        chk("rw_go", fir_go, 1);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rw_ready", in_ready, 1);
        chk("rw_wadj", fir_wadj, 0);
        chk("rw_cnt", sample_cnt, 0);
        repeat (5) step();
        fir_done = 1'b1; fir_sample = 16'h5555;
        step();
        fir_done = 1'b0;
        step();
        chk("rw_no_out", out_valid, 0);
        chk("rw_cnt_after", sample_cnt, 0);
        chk("rw_ready_after", in_ready, 1);
        // counter wrap
        for (int i = 0; i < 16; i++) txn(16'(i), 16'h0000, 16'h0000, 16'h0000, 16'(i + 1), w);
        chk("wrap_zero", sample_cnt, 0);
        txn(16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0011, w);
        chk("wrap_one", sample_cnt, 1);
        fir_done = 1'b1; fir_sample = 16'h6666;
        step();
        fir_done = 1'b0;
        step();
        chk("idle_done_cnt", sample_cnt, 1);
        chk("idle_done_ov", out_valid, 0);
        held = out_sample;
        chk("idle_done_sample", held, 16'h0011);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fir_sample_ctrl.md
Name: fir_sample_ctrl

Overview:
- Sample-rate controller directly upstream of the adaptive FIR engine.
- Accepts one reference/primary/error sample set per transaction over a valid/ready handshake.
- Computes the saturated weight-adjust term mu*err, pulses the FIR start, and holds FIR inputs stable until the FIR signals completion.
- Captures the FIR result into a one-entry output register drained by a valid/ready handshake; also supervises the FIR with a completion timeout.

Parameters:
- TIMEOUT_CYC, 255, max cycles to wait in WAIT for fir_done before aborting (FIR nominally needs TAPS+7).
- CNT_W, 16, width of the completed-sample counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample set valid.
- in_ready  out  1  block can accept an input sample set.
- in_x  in  16  signed reference sample (Q1.15).
- in_a  in  16  signed accumulator seed sample (Q1.15).
- in_err  in  16  signed error sample (Q1.15).
- mu  in  16  signed step size (Q1.15), sampled at the input handshake.
- fir_x  out  16  to FIR x_in.
- fir_a  out  16  to FIR a_in.
- fir_wadj  out  16  to FIR weight_adjust.
- fir_go  out  1  one-cycle FIR start pulse.
- fir_done  in  1  FIR completion pulse.
- fir_sample  in  16  FIR out_sample, valid with fir_done.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_sample  out  16  signed result.
- timeout_err  out  1  sticky FIR timeout flag.
- clr_err  in  1  clears timeout_err.
- sample_cnt  out  CNT_W  completed results, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at an edge, from any state, including mid-transaction):
  - State returns to IDLE.
  - All outputs 0, except in_ready=1.
  - Timeout counter cleared.
  - An in-flight FIR result is discarded: a fir_done arriving after reset is ignored.
- FSM states:
  - IDLE: in_ready = !out_valid.
    - On in_valid && in_ready: register in_x, in_a, in_err, mu → MULT.
  - MULT (1 cycle):
    - p = mu*err as a 32-bit signed product; q = p>>>15 as 17-bit signed.
    - fir_wadj = q saturated to [-32768, 32767].
    - fir_x/fir_a load the captured in_x/in_a → GO.
  - GO (1 cycle): fir_go=1 → WAIT.
  - WAIT: fir_go=0.
    - Timeout counter increments each cycle.
    - On fir_done: out_sample ← fir_sample, out_valid ← 1 (visible next cycle), sample_cnt+1 → IDLE.
    - Else if counter reaches TIMEOUT_CYC: timeout_err ← 1, no output, no count → IDLE.
- fir_x, fir_a and fir_wadj hold their values from MULT through WAIT and until the next MULT; they never change during WAIT.
- in_ready is 0 in MULT, GO and WAIT.
- fir_done outside WAIT is ignored.
- Latency:
  - Handshake at edge T → fir_go high during cycle T+2.
  - fir_done sampled at edge D → out_valid high from D+1.
- Output handshake:
  - out_valid/out_sample are held stable until the edge with out_ready=1; out_valid then drops.
  - A new input is accepted only once out_valid=0, so the output register never overflows.
- Error flag:
  - clr_err clears timeout_err.
  - A timeout and clr_err in the same cycle leave the flag set (set wins).
- sample_cnt wraps from 2^CNT_W−1 to 0.

Test Plan:
- Basic flow: mu=0x4000, err=0x2000, x=0x0100, a=0x0200; FIR model returns 0x1234 with done 134 cycles after go → fir_wadj=0x1000, fir_go exactly one cycle at T+2, out_sample=0x1234, out_valid at D+1, sample_cnt=1.
- Saturation:
  - mu=0x8000, err=0x8000 → fir_wadj=0x7FFF.
  - mu=0x7FFF, err=0x8000 → fir_wadj=0x8001.
  - mu=0xC000, err=0x4000 → fir_wadj=0xE000.
- Backpressure: out_ready=0 for 50 cycles after result, in_valid held high → in_ready=0 and out_sample stable throughout; on the out_ready pulse, out_valid drops and the next input is accepted the following cycle.
- Timeout: FIR model never asserts done → timeout_err=1 exactly TIMEOUT_CYC cycles into WAIT, out_valid stays 0, in_ready returns 1; clr_err clears the flag; a late fir_done is ignored.
- Reset mid-WAIT: rst pulsed 10 cycles after fir_go, FIR done arrives later → no out_valid, sample_cnt=0, in_ready=1.
- Counter wrap: CNT_W=4, run 17 transactions → sample_cnt=1; spurious fir_done in IDLE does not change the count.
